// File: rtl/control_sequencer_if.sv
// Control bundle between the instruction sequencer (master) and the datapath (slave).
// The sequencer samples IR_In/ZCNO and drives every select, enable and status line.
interface control_sequencer_if;
    logic [15:0] IR_In;
    logic [3:0]  ZCNO;
    logic [1:0]  MuxASel;
    logic [1:0]  MuxBSel;
    logic        MuxCSel;
    logic [2:0]  RF_OutASel;
    logic [2:0]  RF_OutBSel;
    logic [1:0]  RF_FunSel;
    logic [3:0]  RF_TSel;
    logic [3:0]  RF_RSel;
    logic [3:0]  ALU_FunSel;
    logic [1:0]  ARF_OutASel;
    logic [1:0]  ARF_OutBSel;
    logic [1:0]  ARF_FunSel;
    logic [3:0]  ARF_RSel;
    logic [1:0]  IR_Funsel;
    logic        IR_Enable;
    logic        IR_LH;
    logic        Mem_WR;
    logic        Mem_CS;
    logic [2:0]  State;
    logic        Halted;
    logic        Illegal;

    modport master (
        input  IR_In, ZCNO,
        output MuxASel, MuxBSel, MuxCSel,
        output RF_OutASel, RF_OutBSel, RF_FunSel, RF_TSel, RF_RSel,
        output ALU_FunSel,
        output ARF_OutASel, ARF_OutBSel, ARF_FunSel, ARF_RSel,
        output IR_Funsel, IR_Enable, IR_LH,
        output Mem_WR, Mem_CS,
        output State, Halted, Illegal
    );

    modport slave (
        output IR_In, ZCNO,
        input  MuxASel, MuxBSel, MuxCSel,
        input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_TSel, RF_RSel,
        input  ALU_FunSel,
        input  ARF_OutASel, ARF_OutBSel, ARF_FunSel, ARF_RSel,
        input  IR_Funsel, IR_Enable, IR_LH,
        input  Mem_WR, Mem_CS,
        input  State, Halted, Illegal
    );
endinterface

// File: rtl/control_sequencer.sv
// Five-phase fetch/decode/execute sequencer: F0/F1 fetch IR bytes, DEC latches fields,
// E1 sets up datapath selects, E2 holds them and commits the write; opcode 0xF halts.
module control_sequencer (
    input  logic                       Clock,
    input  logic                       Reset,
    control_sequencer_if.master        bus
);
    typedef enum logic [2:0] {
        F0  = 3'd0,
        F1  = 3'd1,
        DEC = 3'd2,
        E1  = 3'd3,
        E2  = 3'd4,
        HLT = 3'd5
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [3:0]  opcode_q;
    logic [1:0]  rx_q;
    logic [1:0]  ry_q;
    logic [7:0]  imm_q;
    logic [3:0]  exec_op;
    logic [1:0]  exec_rx;
    logic [1:0]  exec_ry;
    logic [3:0]  arf_rsel_q;
    logic [1:0]  arf_funsel_q;
    logic        branch_armed;
    logic        unused_bits;

    always_comb begin
        next_state = F0;
        case (state)
            F0:      next_state = F1;
            F1:      next_state = DEC;
            DEC:     next_state = (bus.IR_In[15:12] == 4'hF) ? HLT : E1;
            E1:      next_state = E2;
            E2:      next_state = F0;
            HLT:     next_state = HLT;
            default: next_state = F0;
        endcase
    end

    // Outputs are registered against the state being entered, so E1's decode must
    // see the fields being latched this edge rather than the stale latched copy.
    assign exec_op = (state == DEC) ? bus.IR_In[15:12] : opcode_q;
    assign exec_rx = (state == DEC) ? bus.IR_In[11:10] : rx_q;
    assign exec_ry = (state == DEC) ? bus.IR_In[9:8]   : ry_q;

    always_ff @(posedge Clock) begin
        bus.MuxASel     <= '0;
        bus.MuxBSel     <= '0;
        bus.MuxCSel     <= 1'b0;
        bus.RF_OutASel  <= '0;
        bus.RF_OutBSel  <= '0;
        bus.RF_FunSel   <= '0;
        bus.RF_TSel     <= '0;
        bus.RF_RSel     <= '0;
        bus.ALU_FunSel  <= '0;
        bus.ARF_OutASel <= '0;
        bus.ARF_OutBSel <= '0;
        bus.IR_Funsel   <= '0;
        bus.IR_Enable   <= 1'b0;
        bus.IR_LH       <= 1'b0;
        bus.Mem_WR      <= 1'b0;
        bus.Mem_CS      <= 1'b1;
        bus.Halted      <= 1'b0;
        bus.Illegal     <= 1'b0;
        arf_rsel_q      <= '0;
        arf_funsel_q    <= '0;
        branch_armed    <= 1'b0;
        if (Reset) begin
            state    <= F0;
            opcode_q <= '0;
            rx_q     <= '0;
            ry_q     <= '0;
            imm_q    <= '0;
        end else begin
            state <= next_state;
            if (state == DEC) begin
                opcode_q <= bus.IR_In[15:12];
                rx_q     <= bus.IR_In[11:10];
                ry_q     <= bus.IR_In[9:8];
                imm_q    <= bus.IR_In[7:0];
            end
            case (next_state)
                F0, F1: begin
                    bus.ARF_OutBSel <= 2'b00;
                    bus.Mem_CS      <= 1'b0;
                    bus.IR_Enable   <= 1'b1;
                    bus.IR_LH       <= (next_state == F1);
                    bus.IR_Funsel   <= 2'b01;
                    arf_rsel_q      <= 4'b0001;
                    arf_funsel_q    <= 2'b01;
                end
                E1, E2: begin
                    case (exec_op)
                        4'h1: begin
                            bus.MuxASel <= 2'b10;
                            if (next_state == E2) begin
                                bus.RF_RSel   <= 4'b1000 >> exec_rx;
                                bus.RF_FunSel <= 2'b01;
                            end
                        end
                        4'h2: begin
                            bus.RF_OutASel <= {1'b0, exec_rx};
                            bus.RF_OutBSel <= {1'b0, exec_ry};
                            bus.MuxCSel    <= 1'b0;
                            bus.ALU_FunSel <= 4'b0100;
                            bus.MuxASel    <= 2'b00;
                            if (next_state == E2) begin
                                bus.RF_RSel   <= 4'b1000 >> exec_rx;
                                bus.RF_FunSel <= 2'b01;
                            end
                        end
                        4'h3: begin
                            bus.RF_OutASel  <= {1'b0, exec_rx};
                            bus.MuxCSel     <= 1'b0;
                            bus.ALU_FunSel  <= 4'b0000;
                            bus.ARF_OutBSel <= 2'b01;
                            if (next_state == E2) begin
                                bus.Mem_CS <= 1'b0;
                                bus.Mem_WR <= 1'b1;
                            end
                        end
                        4'h4: begin
                            bus.MuxBSel  <= 2'b10;
                            branch_armed <= (next_state == E2);
                        end
                        default: bus.Illegal <= (exec_op != 4'h0);
                    endcase
                end
                HLT:     bus.Halted <= 1'b1;
                default: ;
            endcase
        end
    end

    // The branch condition must be the Z flag seen during E2 itself, so the PC load
    // enable is qualified combinationally on top of the registered E2 marker.
    assign bus.ARF_RSel   = (branch_armed && bus.ZCNO[3]) ? 4'b0001 : arf_rsel_q;
    assign bus.ARF_FunSel = (branch_armed && bus.ZCNO[3]) ? 2'b10   : arf_funsel_q;
    assign bus.State      = state;

    // imm is held for visibility only; the datapath routes IR to MuxA itself.
    assign unused_bits = ^{imm_q, bus.ZCNO[2:0]};
endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a phase/instruction model predicts every
// output each cycle, and directed instruction scenarios pin the model with literals.
module tb_control_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    control_sequencer_if bus();

    control_sequencer dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] mux_a;
        logic [1:0] mux_b;
        logic       mux_c;
        logic [2:0] rf_outa;
        logic [2:0] rf_outb;
        logic [1:0] rf_fun;
        logic [3:0] rf_tsel;
        logic [3:0] rf_rsel;
        logic [3:0] alu_fun;
        logic [1:0] arf_outa;
        logic [1:0] arf_outb;
        logic [1:0] arf_fun;
        logic [3:0] arf_rsel;
        logic [1:0] ir_fun;
        logic       ir_enable;
        logic       ir_lh;
        logic       mem_wr;
        logic       mem_cs;
    } ctrl_t;

    typedef struct packed {
        logic [2:0] st;
        logic       halted;
        logic       illegal;
        ctrl_t      c;
    } snap_t;

    int errors = 0;
    int checks = 0;

    int          m_state = 0;
    bit          m_fresh = 1'b1;
    bit          m_valid = 1'b0;
    logic [15:0] m_instr = '0;

    snap_t last;
    snap_t s [5];
    int    seq_exp [6] = '{0, 1, 2, 3, 4, 0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic ctrl_t dut_ctrl();
        ctrl_t c;
        c.mux_a     = bus.MuxASel;
        c.mux_b     = bus.MuxBSel;
        c.mux_c     = bus.MuxCSel;
        c.rf_outa   = bus.RF_OutASel;
        c.rf_outb   = bus.RF_OutBSel;
        c.rf_fun    = bus.RF_FunSel;
        c.rf_tsel   = bus.RF_TSel;
        c.rf_rsel   = bus.RF_RSel;
        c.alu_fun   = bus.ALU_FunSel;
        c.arf_outa  = bus.ARF_OutASel;
        c.arf_outb  = bus.ARF_OutBSel;
        c.arf_fun   = bus.ARF_FunSel;
        c.arf_rsel  = bus.ARF_RSel;
        c.ir_fun    = bus.IR_Funsel;
        c.ir_enable = bus.IR_Enable;
        c.ir_lh     = bus.IR_LH;
        c.mem_wr    = bus.Mem_WR;
        c.mem_cs    = bus.Mem_CS;
        return c;
    endfunction

    // Expected control word for a phase, straight from the instruction table.
    function automatic ctrl_t model_ctrl(input int st, input bit fresh, input logic [15:0] ins, input logic z);
        ctrl_t      c;
        logic [3:0] op;
        int         rx;
        int         ry;
        bit         commit;
        c = '0;
        c.mem_cs = 1'b1;
        op = ins[15:12];
        rx = int'(ins[11:10]);
        ry = int'(ins[9:8]);
        commit = (st == 4);
        if ((st == 0 && !fresh) || st == 1) begin
            c.mem_cs    = 1'b0;
            c.ir_enable = 1'b1;
            c.ir_lh     = (st == 1);
            c.ir_fun    = 2'b01;
            c.arf_rsel  = 4'b0001;
            c.arf_fun   = 2'b01;
        end else if (st == 3 || st == 4) begin
            case (op)
                4'h1: begin
                    c.mux_a = 2'b10;
                    if (commit) begin
                        c.rf_rsel[3 - rx] = 1'b1;
                        c.rf_fun = 2'b01;
                    end
                end
                4'h2: begin
                    c.rf_outa = 3'(rx);
                    c.rf_outb = 3'(ry);
                    c.alu_fun = 4'd4;
                    if (commit) begin
                        c.rf_rsel[3 - rx] = 1'b1;
                        c.rf_fun = 2'b01;
                    end
                end
                4'h3: begin
                    c.rf_outa  = 3'(rx);
                    c.arf_outb = 2'b01;
                    if (commit) begin
                        c.mem_cs = 1'b0;
                        c.mem_wr = 1'b1;
                    end
                end
                4'h4: begin
                    c.mux_b = 2'b10;
                    if (commit && z) begin
                        c.arf_rsel = 4'b0001;
                        c.arf_fun  = 2'b10;
                    end
                end
                default: ;
            endcase
        end
        return c;
    endfunction

    // Phase model: 0..4 ring, DEC diverts 0xF to the absorbing halt phase.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_state = 0;
            m_fresh = 1'b1;
            m_instr = '0;
            m_valid = 1'b1;
        end else begin
            m_fresh = 1'b0;
            if (m_state == 2) begin
                m_instr = bus.IR_In;
                m_state = (bus.IR_In[15:12] == 4'hF) ? 5 : 3;
            end else if (m_state != 5) begin
                m_state = (m_state + 1) % 5;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check("state", 64'(bus.State), 64'(m_state));
            check("halted", 64'(bus.Halted), 64'(m_state == 5));
            check("illegal", 64'(bus.Illegal),
                  64'((m_state == 3 || m_state == 4) && m_instr[15:12] >= 4'h5 && m_instr[15:12] <= 4'hE));
            check("ctrl", 64'(dut_ctrl()), 64'(model_ctrl(m_state, m_fresh, m_instr, bus.ZCNO[3])));
        end
    end

    task automatic cyc(input logic [15:0] ir, input logic [3:0] z, input logic r);
        bus.IR_In = ir;
        bus.ZCNO  = z;
        rst       = r;
        @(negedge clk);
        last.st      = bus.State;
        last.halted  = bus.Halted;
        last.illegal = bus.Illegal;
        last.c       = dut_ctrl();
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [15:0] ir, input logic [3:0] z_e2, input logic [3:0] z_other);
        for (int i = 0; i < 5; i++) begin
            cyc(ir, (i == 4) ? z_e2 : z_other, 1'b0);
            s[i] = last;
        end
    endtask

    initial begin
        int cnt;
        bus.IR_In = '0;
        bus.ZCNO  = '0;

        cyc(16'h0000, 4'h0, 1'b1);
        cyc(16'h0000, 4'h0, 1'b1);
        check("reset_state", 64'(last.st), 64'd0);
        check("reset_halted", 64'(last.halted), 64'd0);
        check("reset_illegal", 64'(last.illegal), 64'd0);
        check("reset_mem_cs", 64'(last.c.mem_cs), 64'd1);
        check("reset_ir_enable", 64'(last.c.ir_enable), 64'd0);

        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(16'h0000, 4'h0, 1'b0);
            check($sformatf("nop_seq%0d", i), 64'(last.st), 64'(seq_exp[i]));
            if (last.c.arf_rsel == 4'b0001 && last.c.arf_fun == 2'b01) cnt++;
        end
        check("pc_inc_count", 64'(cnt), 64'd2);

        cyc(16'h0000, 4'h0, 1'b1);
        run_instr(16'h1A5C, 4'h0, 4'h0);
        check("ldi_e2_mux_a", 64'(s[4].c.mux_a), 64'd2);
        check("ldi_e2_rf_rsel", 64'(s[4].c.rf_rsel), 64'h2);
        check("ldi_e2_rf_fun", 64'(s[4].c.rf_fun), 64'd1);
        check("ldi_e1_rf_rsel", 64'(s[3].c.rf_rsel), 64'd0);
        check("ldi_e1_mux_a", 64'(s[3].c.mux_a), 64'd2);
        run_instr(16'h2600, 4'hF, 4'hF);
        check("add_f0_fetch", 64'(s[0].c.ir_enable), 64'd1);
        check("add_e2_outa", 64'(s[4].c.rf_outa), 64'd1);
        check("add_e2_outb", 64'(s[4].c.rf_outb), 64'd2);
        check("add_e2_alu", 64'(s[4].c.alu_fun), 64'd4);
        check("add_e2_rf_rsel", 64'(s[4].c.rf_rsel), 64'h4);

        cyc(16'h0000, 4'h0, 1'b1);
        run_instr(16'h4030, 4'b1000, 4'b0000);
        check("beq_taken_rsel", 64'(s[4].c.arf_rsel), 64'd1);
        check("beq_taken_fun", 64'(s[4].c.arf_fun), 64'd2);
        run_instr(16'h4030, 4'b0000, 4'b1000);
        check("beq_not_taken_rsel", 64'(s[4].c.arf_rsel), 64'd0);
        check("beq_not_taken_fun", 64'(s[4].c.arf_fun), 64'd0);
        check("beq_e1_ignores_z", 64'(s[3].c.arf_rsel), 64'd0);
        check("beq_e2_mux_b", 64'(s[4].c.mux_b), 64'd2);

        cyc(16'h0000, 4'h0, 1'b1);
        run_instr(16'h3400, 4'h0, 4'h0);
        cnt = 0;
        for (int i = 0; i < 5; i++) if (s[i].c.mem_wr) cnt++;
        check("st_write_count", 64'(cnt), 64'd1);
        check("st_e2_mem_wr", 64'(s[4].c.mem_wr), 64'd1);
        check("st_e2_mem_cs", 64'(s[4].c.mem_cs), 64'd0);
        check("st_e1_mem_cs", 64'(s[3].c.mem_cs), 64'd1);

        cyc(16'h0000, 4'h0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(16'hF000, 4'hF, 1'b0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(16'h1A5C, 4'(i), 1'b0);
            if (last.st == 3'd5 && last.halted) cnt++;
        end
        check("halt_persist", 64'(cnt), 64'd20);
        cyc(16'h0000, 4'h0, 1'b1);
        cyc(16'h0000, 4'h0, 1'b0);
        check("halt_reset_state", 64'(last.st), 64'd0);
        check("halt_reset_halted", 64'(last.halted), 64'd0);

        cyc(16'h0000, 4'h0, 1'b1);
        run_instr(16'h7000, 4'h0, 4'h0);
        check("ill_e1", 64'(s[3].illegal), 64'd1);
        check("ill_e2", 64'(s[4].illegal), 64'd1);
        cyc(16'h0000, 4'h0, 1'b0);
        check("ill_f0_clear", 64'(last.illegal), 64'd0);

        cyc(16'h0000, 4'h0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(16'h7000, 4'h0, 1'b0);
        cyc(16'h7000, 4'h0, 1'b1);
        check("ill_rst_e1_state", 64'(last.st), 64'd3);
        check("ill_rst_e1_flag", 64'(last.illegal), 64'd1);
        cyc(16'h0000, 4'h0, 1'b0);
        check("ill_rst_next_state", 64'(last.st), 64'd0);
        check("ill_rst_next_ir_en", 64'(last.c.ir_enable), 64'd0);
        check("ill_rst_next_illegal", 64'(last.illegal), 64'd0);
        check("ill_rst_next_mem_cs", 64'(last.c.mem_cs), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
